flag_cond_unit: RTL and testbench
=================================

# flag_cond_unit

Reader side of the 6-bit processor flags register. It accepts a branch-evaluation request carrying a 4-bit condition code and a target address, and waits out any flag write landing in the same cycle. It then evaluates the condition against the stable flag value and returns taken/not-taken with a PC-load strobe to the fetch stage.

## Interface
- ADDR_W, 8, width of branch target and PC-load address
- CNT_W, 16, width of statistics counters (used only with FLAG_COND_STATS_EN)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- flags  in  6  current output of flags register; [0]=Z, [1]=C, [2]=N, [3]=V, [4]=P (even parity), [5]=U (user)
- flags_wr  in  1  flags register write-enable (its control input); high = flags change at this edge
- req  in  1  evaluation request; held high with cond/target stable until ack
- cond  in  4  condition code
- target  in  ADDR_W  branch target
- ack  out  1  one-cycle pulse: result valid, request consumed
- taken  out  1  condition result, valid with ack, held until next ack
- pc_load  out  1  one-cycle pulse, equals ack & taken
- pc_addr  out  ADDR_W  target latched at acceptance, valid with pc_load
- busy  out  1  high in WAIT or EVAL
- taken_cnt, nottaken_cnt  out  CNT_W  statistics (only with FLAG_COND_STATS_EN)

## Operation
- FSM states: IDLE, WAIT, EVAL.
- IDLE: on req, latch cond and target. If flags_wr=1 in that cycle, go to WAIT; else go to EVAL.
- WAIT: stay while flags_wr=1; go to EVAL on the first cycle with flags_wr=0.
- EVAL: sample flags, compute result, pulse ack (plus pc_load if taken), return to IDLE.
- req sampled in the ack cycle is ignored. Requester must drop req after ack. A new request is accepted the cycle after ack.
- A flags_wr pulse in the EVAL cycle does not alter the result; the value sampled is the pre-write value at that edge.
- Condition codes:
  - 0 always
  - 1 never
  - 2 Z
  - 3 !Z
  - 4 C
  - 5 !C
  - 6 N
  - 7 !N
  - 8 V
  - 9 !V
  - 10 C&!Z (unsigned >)
  - 11 !C|Z (unsigned <=)
  - 12 N==V (signed >=)
  - 13 N!=V (signed <)
  - 14 !Z&(N==V) (signed >)
  - 15 P
- Bit U is not used by any condition.

## Timing
- Reset values: state=IDLE, ack=0, taken=0, pc_load=0, pc_addr=0, busy=0, counters=0.
- Latency, req with flags_wr=0: req at edge k, ack/taken/pc_load at edge k+2.
- Latency, req with flags_wr=1: one extra cycle per consecutive flags_wr cycle.
- rst mid-operation: FSM returns to IDLE and drops the pending request with no ack. Outputs take their reset values at that edge.
- rst has priority over req in the same cycle.

## Configuration
- FLAG_COND_STATS_EN defined: taken_cnt and nottaken_cnt exist.
  - Each ack increments exactly one of them, by the taken value.
  - Counters saturate at all-ones; no wrap.
  - Both are cleared by rst.
- FLAG_COND_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles, req=1 -> ack=0, busy=0, taken=0, pc_addr=0; no ack appears after release until req is re-sampled.
- Basic: flags=6'b000001, cond=2, target=8'h3C, req with flags_wr=0 -> ack 2 edges later, taken=1, pc_load=1, pc_addr=8'h3C. Repeat with cond=3 -> taken=0, pc_load=0.
- Hazard: flags=000000, flags_wr=1 for 2 cycles writing 000010 at the req cycle; cond=4 -> busy for 3 cycles, ack at edge k+4, taken=1 (new C is used).
- Signed/unsigned sweep: flags with N=1,V=0 -> cond13=1, cond12=0, cond14=0. Flags with C=1,Z=0 -> cond10=1, cond11=0. Cycle all 16 codes against 6'b101010 and check against the table.
- Mid-operation reset: req with flags_wr held high (WAIT), assert rst -> no ack, state IDLE, busy=0. A following req completes normally.
- Stats (FLAG_COND_STATS_EN, CNT_W=2): 5 taken requests -> taken_cnt=3 (saturated), nottaken_cnt=0. Then rst -> both 0.

Source files
------------

// File: rtl/flag_cond_unit.sv
// Branch-condition evaluator on the read side of the 6-bit flags register.
// Optional macro FLAG_COND_STATS_EN adds saturating taken/not-taken counters.
module flag_cond_unit #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        flags,
    input  logic              flags_wr,
    input  logic              req,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] target,
    output logic              ack,
    output logic              taken,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_addr,
`ifdef FLAG_COND_STATS_EN
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

    state_t     state, state_n;
    logic [3:0] cond_q;
    logic       accept;
    logic       result;

    // Flag bit U carries no condition; it is deliberately left unobserved.
    logic unused_flag_u;
    assign unused_flag_u = flags[5];

    function automatic logic cond_hit(input logic [3:0] c, input logic [5:0] f);
        logic z, cy, n, v, p;
        z  = f[0];
        cy = f[1];
        n  = f[2];
        v  = f[3];
        p  = f[4];
        case (c)
            4'd0:    cond_hit = 1'b1;
            4'd1:    cond_hit = 1'b0;
            4'd2:    cond_hit = z;
            4'd3:    cond_hit = ~z;
            4'd4:    cond_hit = cy;
            4'd5:    cond_hit = ~cy;
            4'd6:    cond_hit = n;
            4'd7:    cond_hit = ~n;
            4'd8:    cond_hit = v;
            4'd9:    cond_hit = ~v;
            4'd10:   cond_hit = cy & ~z;
            4'd11:   cond_hit = ~cy | z;
            4'd12:   cond_hit = (n == v);
            4'd13:   cond_hit = (n != v);
            4'd14:   cond_hit = ~z & (n == v);
            default: cond_hit = p;
        endcase
    endfunction

    assign result = cond_hit(cond_q, flags);
    assign busy   = (state == WAIT) || (state == EVAL);

    // A request still high during the ack cycle must not be re-accepted.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req && !ack) begin
                    accept  = 1'b1;
                    state_n = flags_wr ? WAIT : EVAL;
                end
            end
            WAIT: begin
                if (!flags_wr) begin
                    state_n = EVAL;
                end
            end
            EVAL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cond_q  <= '0;
            pc_addr <= '0;
            ack     <= 1'b0;
            taken   <= 1'b0;
            pc_load <= 1'b0;
        end else begin
            state   <= state_n;
            ack     <= 1'b0;
            pc_load <= 1'b0;
            if (accept) begin
                cond_q  <= cond;
                pc_addr <= target;
            end
            if (state == EVAL) begin
                ack     <= 1'b1;
                taken   <= result;
                pc_load <= result;
            end
        end
    end

`ifdef FLAG_COND_STATS_EN
    // Exactly one counter advances per evaluation, and neither wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (state == EVAL) begin
            if (result) begin
                if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            end else begin
                if (nottaken_cnt != '1) nottaken_cnt <= nottaken_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: vector table, scoreboard, corner sequences.
// Define FLAG_COND_STATS_EN to also exercise the statistics counters.
module tb_flag_cond_unit;

`ifdef FLAG_COND_STATS_EN
    localparam int TB_CNT_W = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] flags;
    logic       flags_wr;
    logic       req;
    logic [3:0] cond;
    logic [7:0] target;
    logic       ack;
    logic       taken;
    logic       pc_load;
    logic [7:0] pc_addr;
    logic       busy;
`ifdef FLAG_COND_STATS_EN
    logic [TB_CNT_W-1:0] taken_cnt;
    logic [TB_CNT_W-1:0] nottaken_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       taken;
        logic [7:0] addr;
    } exp_t;

    typedef struct {
        logic [5:0] flags;
        logic [3:0] cond;
        logic [7:0] target;
        logic       taken;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

`ifdef FLAG_COND_STATS_EN
    flag_cond_unit #(.ADDR_W(8), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .flags(flags), .flags_wr(flags_wr), .req(req),
        .cond(cond), .target(target), .ack(ack), .taken(taken),
        .pc_load(pc_load), .pc_addr(pc_addr),
        .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt), .busy(busy)
    );
`else
    flag_cond_unit #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flags(flags), .flags_wr(flags_wr), .req(req),
        .cond(cond), .target(target), .ack(ack), .taken(taken),
        .pc_load(pc_load), .pc_addr(pc_addr), .busy(busy)
    );
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [5:0] f, input logic [3:0] c,
                          input logic [7:0] t, input logic tk);
        vec_t v;
        v.flags  = f;
        v.cond   = c;
        v.target = t;
        v.taken  = tk;
        vecs.push_back(v);
    endtask

    // Drives one request: flags_wr is held for wr_cycles edges (flags becomes f1
    // after each write edge); eval_wr pulses a write during the EVAL cycle; hold
    // keeps req high through the ack cycle.
    task automatic applyStimulus(input logic [5:0] f0, input logic [5:0] f1,
                                 input int wr_cycles, input logic [3:0] c,
                                 input logic [7:0] t, input logic exp_taken,
                                 input bit hold, input bit eval_wr);
        exp_t e;
        int   busy_cnt;
        bit   got;
        @(negedge clk);
        flags    = f0;
        cond     = c;
        target   = t;
        req      = 1'b1;
        flags_wr = (wr_cycles > 0);
        e.taken  = exp_taken;
        e.addr   = t;
        sb.push_back(e);
        busy_cnt = 0;
        got      = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (got) break;
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                checkOutput("latency", cyc, wr_cycles + 2);
                checkOutput("busy_cycles", busy_cnt, wr_cycles + 1);
                checkOutput("taken", taken, e.taken);
                checkOutput("pc_load", pc_load, e.taken);
                checkOutput("pc_addr", pc_addr, e.addr);
                checkOutput("busy_at_ack", busy, 0);
                if (eval_wr) begin
                    flags    = ~f0 & 6'h0F;
                    flags_wr = 1'b0;
                end
                if (!hold) req = 1'b0;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (cyc <= wr_cycles) flags = f1;
                if (cyc >= wr_cycles) flags_wr = 1'b0;
                if (eval_wr && cyc == wr_cycles + 1) flags_wr = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no ack, expected ack within 20 cycles");
            void'(sb.pop_back());
            req      = 1'b0;
            flags_wr = 1'b0;
        end
        @(negedge clk);
        checkOutput("ack_pulse", ack, 0);
        checkOutput("pc_load_pulse", pc_load, 0);
        checkOutput("taken_hold", taken, exp_taken);
        if (hold) begin
            checkOutput("req_in_ack_cycle_ignored", busy, 0);
            req = 1'b0;
            @(negedge clk);
            checkOutput("no_second_ack", ack, 0);
            checkOutput("still_idle", busy, 0);
        end
    endtask

    initial begin
        logic [15:0] sweep_exp;
        rst      = 1'b1;
        req      = 1'b1;
        flags    = 6'b000000;
        flags_wr = 1'b0;
        cond     = 4'd0;
        target   = 8'hAA;

        // Reset held with req asserted: reset wins, outputs stay at reset values.
        repeat (2) @(negedge clk);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_taken", taken, 0);
        checkOutput("reset_pc_load", pc_load, 0);
        checkOutput("reset_pc_addr", pc_addr, 0);
        rst = 1'b0;
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_no_ack", ack, 0);
        end

        addVec(6'b000001, 4'd2,  8'h3C, 1'b1);
        addVec(6'b000001, 4'd3,  8'h3C, 1'b0);
        addVec(6'b000100, 4'd13, 8'h21, 1'b1);
        addVec(6'b000100, 4'd12, 8'h22, 1'b0);
        addVec(6'b000100, 4'd14, 8'h23, 1'b0);
        addVec(6'b000010, 4'd10, 8'h24, 1'b1);
        addVec(6'b000010, 4'd11, 8'h25, 1'b0);
        addVec(6'b000011, 4'd10, 8'h26, 1'b0);
        addVec(6'b000011, 4'd11, 8'h27, 1'b1);
        addVec(6'b001100, 4'd14, 8'h28, 1'b1);
        addVec(6'b001100, 4'd12, 8'h29, 1'b1);
        addVec(6'b010000, 4'd15, 8'h2A, 1'b1);
        addVec(6'b100000, 4'd15, 8'h2B, 1'b0);
        addVec(6'b100000, 4'd2,  8'h2C, 1'b0);
        // Against 101010 (Z=0 C=1 N=0 V=1 P=0 U=1); bit i = expected for code i.
        sweep_exp = 16'h2599;
        for (int i = 0; i < 16; i++) begin
            addVec(6'b101010, 4'(i), 8'(8'h40 + i), sweep_exp[i]);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flags, vecs[i].flags, 0, vecs[i].cond,
                          vecs[i].target, vecs[i].taken, 1'b0, 1'b0);
        end

        // Flag-write hazards: the post-write value must be evaluated.
        applyStimulus(6'b000000, 6'b000010, 2, 4'd4, 8'h51, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'b000001, 6'b000000, 1, 4'd2, 8'h77, 1'b0, 1'b0, 1'b0);
        // A write in the EVAL cycle must not affect the result.
        applyStimulus(6'b000001, 6'b000001, 0, 4'd2, 8'h90, 1'b1, 1'b0, 1'b1);
        // req left high through the ack cycle is not a new request.
        applyStimulus(6'b000010, 6'b000010, 0, 4'd5, 8'h91, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b000100, 6'b000100, 0, 4'd6, 8'h92, 1'b1, 1'b0, 1'b0);

        // Reset while parked in WAIT drops the request without an ack.
        @(negedge clk);
        flags    = 6'b000000;
        flags_wr = 1'b1;
        req      = 1'b1;
        cond     = 4'd0;
        target   = 8'hEE;
        repeat (2) @(negedge clk);
        checkOutput("wait_busy", busy, 1);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_ack", ack, 0);
        checkOutput("midreset_taken", taken, 0);
        checkOutput("midreset_pc_addr", pc_addr, 0);
        rst      = 1'b0;
        flags_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_no_ack", ack, 0);
        end
        applyStimulus(6'b001000, 6'b001000, 0, 4'd8, 8'h12, 1'b1, 1'b0, 1'b0);

`ifdef FLAG_COND_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("stats_reset_taken", taken_cnt, 0);
        checkOutput("stats_reset_nottaken", nottaken_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(6'b000000, 6'b000000, 0, 4'd0, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("stats_taken_sat", taken_cnt, 3);
        checkOutput("stats_nottaken_zero", nottaken_cnt, 0);
        applyStimulus(6'b000000, 6'b000000, 0, 4'd1, 8'h70, 1'b0, 1'b0, 1'b0);
        checkOutput("stats_nottaken_one", nottaken_cnt, 1);
        checkOutput("stats_taken_held", taken_cnt, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("stats_clear_taken", taken_cnt, 0);
        checkOutput("stats_clear_nottaken", nottaken_cnt, 0);
`endif

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
